// File: rtl/alu_shift_pkg.sv
// Shared definitions for the ALU-64 shift path: widths, sh_reg mode encoding and sequencer states.
package alu_shift_pkg;

  localparam int unsigned ShW  = 64;
  localparam int unsigned ShD  = 1;
  localparam int unsigned ShAw = $clog2(ShW / ShD) + 1;

  typedef enum logic [2:0] {
    SH_LSL = 3'b000,
    SH_LSR = 3'b001,
    SH_ASL = 3'b010,
    SH_ASR = 3'b011,
    SH_ROL = 3'b100,
    SH_ROR = 3'b101,
    SH_SIL = 3'b110,
    SH_SIR = 3'b111
  } sh_mode_e;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShift,
    StSet1,
    StSet2,
    StDone
  } sh_state_e;

  // More than a full register width of steps is never useful, so saturate there.
  function automatic logic [ShAw-1:0] clamp_steps(input logic [ShAw-1:0] amt);
    logic [ShAw-1:0] max_steps;
    max_steps = ShAw'(ShW / ShD);
    return (amt > max_steps) ? max_steps : amt;
  endfunction

endpackage

// File: rtl/sh_ctrl_if.sv
// Request/response and sh_reg control bundle shared by the requester, sh_ctrl and sh_reg.
interface sh_ctrl_if;
  import alu_shift_pkg::*;

  logic                start;
  logic [2:0]          op;
  logic [ShAw-1:0]     amt;
  logic [ShW-1:0]      operand;
  logic [ShD-1:0]      fill;
  logic [ShW-1:0]      q;
  logic                load;
  logic                sh;
  logic [2:0]          sh_mode;
  logic [ShD-1:0]      sh_in;
  logic [ShW-1:0]      reg_in;
  logic                busy;
  logic                done;
  logic [ShW-1:0]      result;

  // Requester side (opcode decoder).
  modport master (
    output start, op, amt, operand, fill,
    input  busy, done, result
  );

  // Sequencer side.
  modport slave (
    input  start, op, amt, operand, fill, q,
    output load, sh, sh_mode, sh_in, reg_in, busy, done, result
  );

  // Shift register side.
  modport regs (
    input  load, sh, sh_mode, sh_in, reg_in,
    output q
  );

endinterface

// File: rtl/sh_cnt.sv
// Loadable down-counter for the shift sequencer; last_o flags the final step (count == 1).
module sh_cnt #(
  parameter int unsigned Width = 7
) (
  input  logic             clk_i,
  input  logic             rst_b_i,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [Width-1:0] cnt_i,
  output logic             last_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = cnt_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == Width'(1));

endmodule

// File: rtl/sh_reg.sv
// ALU-64 shift register: loadable, d-bit step per sh pulse, with a registered output stage on q_o.
module sh_reg import alu_shift_pkg::*; #(
  parameter int unsigned W = ShW,
  parameter int unsigned D = ShD
) (
  input  logic         clk_i,
  input  logic         rst_b_i,
  input  logic         load_i,
  input  logic         sh_i,
  input  logic [2:0]   sh_mode_i,
  input  logic [D-1:0] sh_in_i,
  input  logic [W-1:0] in_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] r_q, r_d, q_q, shifted;

  always_comb begin
    shifted = r_q;
    case (sh_mode_e'(sh_mode_i))
      SH_LSL, SH_ASL: shifted = {r_q[W-D-1:0], {D{1'b0}}};
      SH_LSR:         shifted = {{D{1'b0}}, r_q[W-1:D]};
      SH_ASR:         shifted = {{D{r_q[W-1]}}, r_q[W-1:D]};
      SH_ROL:         shifted = {r_q[W-D-1:0], r_q[W-1:W-D]};
      SH_ROR:         shifted = {r_q[D-1:0], r_q[W-1:D]};
      SH_SIL:         shifted = {r_q[W-D-1:0], sh_in_i};
      SH_SIR:         shifted = {sh_in_i, r_q[W-1:D]};
      default:        shifted = r_q;
    endcase
  end

  always_comb begin
    r_d = r_q;
    if (load_i) begin
      r_d = in_i;
    end else if (sh_i) begin
      r_d = shifted;
    end
  end

  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      r_q <= '0;
      q_q <= '0;
    end else begin
      r_q <= r_d;
      q_q <= r_q;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/sh_ctrl.sv
// Sequencer for sh_reg: load operand, issue N shift pulses, wait out the register pipeline, return q.
module sh_ctrl import alu_shift_pkg::*; (
  input  logic clk_i,
  input  logic rst_b_i,
  sh_ctrl_if.slave bus
);

  localparam int unsigned W  = ShW;
  localparam int unsigned D  = ShD;
  localparam int unsigned AW = ShAw;

  sh_state_e      state_q;
  logic [AW-1:0]  steps_q;
  logic           load_q;
  logic           sh_q;
  logic [2:0]     sh_mode_q;
  logic [D-1:0]   sh_in_q;
  logic [W-1:0]   reg_in_q;
  logic           busy_q;
  logic           done_q;
  logic [W-1:0]   result_q;

  logic cnt_load, cnt_dec, cnt_last;

  assign cnt_load = (state_q == StLoad) && (steps_q != '0);
  assign cnt_dec  = (state_q == StShift);

  sh_cnt #(
    .Width (AW)
  ) u_cnt (
    .clk_i   (clk_i),
    .rst_b_i (rst_b_i),
    .load_i  (cnt_load),
    .dec_i   (cnt_dec),
    .cnt_i   (steps_q),
    .last_o  (cnt_last)
  );

  // Outputs are registered alongside the state, so each output reflects the state it belongs to.
  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      state_q   <= StIdle;
      steps_q   <= '0;
      load_q    <= 1'b0;
      sh_q      <= 1'b0;
      sh_mode_q <= '0;
      sh_in_q   <= '0;
      reg_in_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q   <= StLoad;
            steps_q   <= clamp_steps(bus.amt);
            sh_mode_q <= bus.op;
            sh_in_q   <= bus.fill;
            reg_in_q  <= bus.operand;
            load_q    <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        StLoad: begin
          load_q   <= 1'b0;
          reg_in_q <= '0;
          if (steps_q == '0) begin
            state_q <= StSet1;
          end else begin
            state_q <= StShift;
            sh_q    <= 1'b1;
          end
        end
        StShift: begin
          if (cnt_last) begin
            sh_q    <= 1'b0;
            state_q <= StSet1;
          end
        end
        StSet1: begin
          state_q <= StSet2;
        end
        StSet2: begin
          state_q  <= StDone;
          result_q <= bus.q;
          done_q   <= 1'b1;
        end
        StDone: begin
          state_q   <= StIdle;
          done_q    <= 1'b0;
          busy_q    <= 1'b0;
          sh_mode_q <= '0;
          sh_in_q   <= '0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.load    = load_q;
  assign bus.sh      = sh_q;
  assign bus.sh_mode = sh_mode_q;
  assign bus.sh_in   = sh_in_q;
  assign bus.reg_in  = reg_in_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.result  = result_q;

endmodule

// File: tb/tb_sh_ctrl.sv
// Bench for sh_ctrl driving a real sh_reg; results checked against an arithmetic shift model.
module tb_sh_ctrl;

  logic clk;
  logic rst_b;
  logic [63:0] q_w;

  int n_vec;
  int n_err;

  sh_ctrl_if bus ();

  sh_ctrl u_dut (
    .clk_i   (clk),
    .rst_b_i (rst_b),
    .bus     (bus)
  );

  sh_reg u_reg (
    .clk_i     (clk),
    .rst_b_i   (rst_b),
    .load_i    (bus.load),
    .sh_i      (bus.sh),
    .sh_mode_i (bus.sh_mode),
    .sh_in_i   (bus.sh_in),
    .in_i      (bus.reg_in),
    .q_o       (q_w)
  );

  assign bus.q = q_w;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clamp(input int amt);
    return (amt > 64) ? 64 : amt;
  endfunction

  function automatic logic [63:0] model(input logic [2:0] op, input int n,
                                        input logic [63:0] x, input logic fill);
    logic [63:0] ones;
    logic signed [63:0] sx;
    ones = '1;
    sx   = x;
    case (op)
      3'd0, 3'd2: return x << n;
      3'd1:       return x >> n;
      3'd3:       return sx >>> n;
      3'd4:       return (x << n) | (x >> (64 - n));
      3'd5:       return (x >> n) | (x << (64 - n));
      3'd6:       return (x << n) | (fill ? ~(ones << n) : 64'd0);
      default:    return (x >> n) | (fill ? ~(ones >> n) : 64'd0);
    endcase
  endfunction

  // Issues one request and observes it cycle by cycle; cycle 0 is the cycle start is sampled.
  task automatic run_op(input logic [2:0] op, input int amt, input logic [63:0] operand,
                        input logic fill, input int glitch_cyc,
                        output logic [63:0] res, output int done_cyc, output int sh_cyc,
                        output bit overlap, output bit mode_bad, output bit busy1,
                        output bit idle_after);
    int cyc;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.amt     = 7'(amt);
    bus.operand = operand;
    bus.fill    = fill;
    @(posedge clk);
    cyc = 1;
    done_cyc = -1;
    sh_cyc = 0;
    overlap = 0;
    mode_bad = 0;
    idle_after = 0;
    res = '0;
    @(negedge clk);
    bus.start = 1'b0;
    busy1 = bus.busy;
    while (cyc < 200) begin
      if (cyc == glitch_cyc) begin
        bus.start   = 1'b1;
        bus.op      = ~op;
        bus.operand = ~operand;
        bus.amt     = 7'(amt + 5);
        bus.fill    = ~fill;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.sh) sh_cyc++;
      if (bus.load && bus.sh) overlap = 1;
      if (bus.sh_mode !== op) mode_bad = 1;
      if (bus.done === 1'b1) begin
        done_cyc = cyc;
        res = bus.result;
        break;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    if (done_cyc >= 0) begin
      @(posedge clk);
      @(negedge clk);
      idle_after = (bus.busy === 1'b0) && (bus.done === 1'b0) && (bus.sh_mode === 3'd0) &&
                   (bus.sh_in === 1'b0) && (bus.result === res);
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    bus.start = 1'b0;
    bus.op = '0;
    bus.amt = '0;
    bus.operand = '0;
    bus.fill = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({bus.load, bus.sh, bus.sh_mode, bus.sh_in, bus.busy, bus.done} !== 8'd0 ||
        bus.reg_in !== 64'd0 || bus.result !== 64'd0) begin
      n_err++;
      $display("FAIL reset_outputs: load=%b sh=%b mode=%0d busy=%b done=%b result=%h want all 0",
               bus.load, bus.sh, bus.sh_mode, bus.busy, bus.done, bus.result);
    end
    rst_b = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed(input string name, input logic [2:0] op, input int amt,
                               input logic [63:0] operand, input logic fill, input int glitch);
    logic [63:0] res, exp;
    int dc, shc, n;
    bit ov, mb, b1, ia;
    n   = clamp(amt);
    exp = model(op, n, operand, fill);
    run_op(op, amt, operand, fill, glitch, res, dc, shc, ov, mb, b1, ia);
    n_vec++;
    if (res !== exp) begin
      n_err++;
      $display("FAIL %s result: got %h want %h", name, res, exp);
    end
    n_vec++;
    if (dc !== n + 4) begin
      n_err++;
      $display("FAIL %s done_cycle: got %0d want %0d", name, dc, n + 4);
    end
    n_vec++;
    if (shc !== n) begin
      n_err++;
      $display("FAIL %s sh_cycles: got %0d want %0d", name, shc, n);
    end
    n_vec++;
    if (ov || mb || !b1 || !ia) begin
      n_err++;
      $display("FAIL %s control: overlap=%b mode_bad=%b busy1=%b idle_after=%b want 0 0 1 1",
               name, ov, mb, b1, ia);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] res;
    int dc, shc;
    bit ov, mb, b1, ia;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = 3'd6;
    bus.amt     = 7'd20;
    bus.operand = {$urandom, $urandom} | 64'h1;
    bus.fill    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    n_vec++;
    if (bus.sh !== 1'b1 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_pre: sh=%b busy=%b want 1 1", bus.sh, bus.busy);
    end
    rst_b = 1'b0;
    #1;
    n_vec++;
    if ({bus.load, bus.sh, bus.sh_mode, bus.sh_in, bus.busy, bus.done} !== 8'd0 ||
        bus.reg_in !== 64'd0 || bus.result !== 64'd0) begin
      n_err++;
      $display("FAIL reset_mid_async: sh=%b mode=%0d sh_in=%b busy=%b result=%h want all 0",
               bus.sh, bus.sh_mode, bus.sh_in, bus.busy, bus.result);
    end
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    repeat (4) @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b0 || bus.sh !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_resume: busy=%b sh=%b done=%b want 0 0 0",
               bus.busy, bus.sh, bus.done);
    end
    run_op(3'd0, 1, 64'h3, 1'b0, -1, res, dc, shc, ov, mb, b1, ia);
    n_vec++;
    if (res !== 64'h6 || dc !== 5) begin
      n_err++;
      $display("FAIL reset_mid_after: result=%h cycle=%0d want 6 at 5", res, dc);
    end
  endtask

  task automatic test_random(input int count);
    logic [63:0] res, exp, opd;
    logic [2:0] op;
    logic fill;
    int amt, n, dc, shc;
    bit ov, mb, b1, ia;
    for (int i = 0; i < count; i++) begin
      op   = 3'($urandom_range(0, 7));
      amt  = (i % 4 == 0) ? $urandom_range(60, 127) : $urandom_range(0, 70);
      opd  = {$urandom, $urandom};
      fill = 1'($urandom);
      n    = clamp(amt);
      exp  = model(op, n, opd, fill);
      run_op(op, amt, opd, fill, (i % 3 == 0) ? 2 : -1, res, dc, shc, ov, mb, b1, ia);
      n_vec++;
      if (res !== exp || dc !== n + 4 || shc !== n || ov || mb || !b1 || !ia) begin
        n_err++;
        $display("FAIL random[%0d] op=%0d amt=%0d opd=%h: result=%h cyc=%0d sh=%0d want %h %0d %0d",
                 i, op, amt, opd, res, dc, shc, exp, n + 4, n);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_directed("lsl4", 3'd0, 4, 64'h1, 1'b0, -1);
    test_directed("asr8", 3'd3, 8, 64'h8000_0000_0000_0000, 1'b0, -1);
    test_directed("ror1", 3'd5, 1, 64'h1, 1'b0, -1);
    test_directed("amt0", 3'd0, 0, 64'hDEAD_BEEF, 1'b0, -1);
    test_directed("clamp", 3'd0, 100, 64'hFFFF_0000_1234_5678, 1'b0, -1);
    test_directed("rol64", 3'd4, 64, 64'hA5A5_0F0F_1234_8001, 1'b0, -1);
    test_directed("sil_glitch", 3'd6, 3, 64'h0, 1'b1, 2);
    test_reset_mid();
    test_random(40);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sh_ctrl.md
# sh_ctrl

Sequencer that drives the ALU-64 shift register (`sh_reg`) from a single-cycle request. It accepts an operand, a shift mode and a step count, then loads the register. It issues exactly that many shift pulses, waits for the register's output stage, and returns the result with a one-cycle `done` pulse. It sits between the ALU opcode decoder and the `sh_reg` instance and owns that register's control inputs.

## Interface
- `w`, 64, data width; equals the `sh_reg` width.
- `d`, 1, bits moved per shift step; equals the `sh_reg` step.
- `AW`, `$clog2(w/d)+1`, width of the step-count input.

- `clk`  in  1  single clock for the block.
- `rst_b`  in  1  asynchronous, active-low reset.
- `start`  in  1  request strobe; sampled only in IDLE.
- `op`  in  3  shift mode, uses the `sh_reg` encoding 000..111.
- `amt`  in  AW  number of d-bit steps.
- `operand`  in  w  value to be shifted.
- `fill`  in  d  serial input bits for modes 110/111.
- `q`  in  w  `sh_reg` output.
- `load`  out  1  to `sh_reg.load`.
- `sh`  out  1  to `sh_reg.sh`.
- `sh_mode`  out  3  to `sh_reg.sh_mode`.
- `sh_in`  out  d  to `sh_reg.sh_in`.
- `reg_in`  out  w  to `sh_reg.in`.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  w  captured shift result; holds its value until the next `done`.

## Operation
- States: IDLE, LOAD, SHIFT, SET1, SET2, DONE.
- **IDLE:** on `start=1`, latch `op`, `operand` and `fill`. Latch the step count as `min(amt, w/d)`. Go to LOAD.
- **LOAD:** `load=1` and `reg_in`=latched operand for one cycle.
  - If the step count is 0, go to SET1.
  - Otherwise load the down-counter with the step count and go to SHIFT.
- **SHIFT:** `sh=1` and `sh_mode`=latched op every cycle. The counter decrements each cycle; after the cycle in which it reaches 1, go to SET1.
- **SET1 / SET2:** no control asserted. These cover the `sh_reg` internal update plus its registered `q` stage.
- **DONE:** at entry, `result <= q`. `done=1` for one cycle, then go to IDLE.
- `load` and `sh` are never high in the same cycle.
- `sh_mode` and `sh_in` hold their latched values from LOAD through DONE. They are 0 in IDLE.
- `start` while `busy` is ignored; it is neither queued nor used to abort.
- A clamped step count of w/d is allowed for every mode. A rotate by w/d steps returns the operand unchanged.
- Reset, including mid-operation:
  - All outputs go to 0: `load`, `sh`, `sh_mode`, `sh_in`, `reg_in`, `busy`, `done`, `result`.
  - The counter goes to 0 and the state goes to IDLE.
  - Nothing resumes after reset is released.

## Timing
- Cycle 0 is the cycle in which `start` is sampled in IDLE.
  - LOAD is cycle 1.
  - SHIFT is cycles 2..N+1, where N is the clamped step count.
  - SET1/SET2 are cycles N+2 and N+3.
  - `done` is high in cycle N+4.
- Total latency from `start` to `done` is N+4 cycles. With N=0 it is 4 cycles, and `sh` is never asserted.
- `busy` rises in cycle 1 and falls after cycle N+4. A new `start` is accepted in cycle N+5 at the earliest.
- All outputs are registered; there is no combinational path from `start` to any output.

## Structure
- Shared package `alu_shift_pkg`:
  - Mode constants: `SH_LSL=000`, `SH_LSR=001`, `SH_ASL=010`, `SH_ASR=011`, `SH_ROL=100`, `SH_ROR=101`, `SH_SIL=110`, `SH_SIR=111`.
  - The state encoding for the FSM above.
- Sub-module `sh_cnt`: an AW-bit loadable down-counter with a `last` flag (count==1). It is the only natural split; the FSM stays in `sh_ctrl`.
- The bench instantiates `sh_ctrl` together with a real `sh_reg` (w=64, d=1).

## Test plan
- LSL, `amt=4`, `operand=64'h1` -> `result=64'h10`; `done` in cycle 8; `sh` high for exactly 4 cycles.
- ASR, `amt=8`, `operand=64'h8000_0000_0000_0000` -> `result=64'hFF80_0000_0000_0000`; `done` in cycle 12.
- ROR, `amt=1`, `operand=64'h1` -> `result=64'h8000_0000_0000_0000`; `load` and `sh` never high together.
- Edge counts:
  - `amt=0`, `operand=64'hDEAD_BEEF` -> `result=64'hDEAD_BEEF`, `done` in cycle 4, `sh` never high.
  - LSL with `amt=100` -> clamped to 64 steps, `result=0`, `done` in cycle 68.
- SIL, `fill=1`, `amt=3`, `operand=0` -> `result=64'h7`. A `start` pulsed in cycle 2 with different data has no effect.
- Reset mid-operation:
  - Drop `rst_b` during SHIFT -> all outputs 0 immediately (asynchronously), state IDLE.
  - After release, LSL `amt=1` `operand=64'h3` -> `result=64'h6` in cycle 5.
